// File: rtl/i2c_master_control.sv
// rtl/i2c_master_control.sv - single-byte I2C master control FSM
//
// Purpose: sequences one I2C master transaction per accepted Go pulse
// (START, address+R/W, ACK, data byte, ACK/NACK, STOP) and drives the
// control inputs of the downstream I2C data unit. SCL timing comes from a
// fractional quarter-tick generator configured by BaudRate/ClockFrequency.
//
// Optional feature macro: CLOCK_STRETCH_EN (adds SCLin; a slave holding SCL
// low while the master releases it high stalls the quarter timing).
//
// Ports:
//   clock          system clock
//   Reset          synchronous, active-high reset
//   Go             start request, only honoured in IDLE
//   RW             0 = write, 1 = read
//   SlaveAddr      7-bit target address
//   WrData         byte to write
//   BaudRate       SCL frequency in Hz (0 disables Go)
//   ClockFrequency system clock frequency in Hz
//   SDAin          sampled SDA line for ACK detection
//   SCLin          sampled SCL line (CLOCK_STRETCH_EN only)
//   SCL            I2C clock
//   WriteLoad      1-cycle load pulse to the data unit
//   ReadorWrite    1 = data unit drives SDA, 0 = release/sample
//   ShiftorHold    1-cycle shift pulse to the data unit
//   Select         SDA source: 0 = StartStopAck, 1 = shift-register MSB
//   StartStopAck   SDA level when Select = 0
//   SentData       byte presented with WriteLoad
//   Busy           transaction in progress
//   Done           1-cycle completion pulse
//   AckError       NACK seen on address/write-data ACK, sticky until next Go
module i2c_master_control (
   input  logic        clock,
   input  logic        Reset,
   input  logic        Go,
   input  logic        RW,
   input  logic [6:0]  SlaveAddr,
   input  logic [7:0]  WrData,
   input  logic [19:0] BaudRate,
   input  logic [29:0] ClockFrequency,
   input  logic        SDAin,
`ifdef CLOCK_STRETCH_EN
   input  logic        SCLin,
`endif
   output logic        SCL,
   output logic        WriteLoad,
   output logic        ReadorWrite,
   output logic        ShiftorHold,
   output logic        Select,
   output logic        StartStopAck,
   output logic [7:0]  SentData,
   output logic        Busy,
   output logic        Done,
   output logic        AckError
);

   typedef enum logic [2:0] {
      IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, DONE
   } stateT;

   stateT       state, stateNext;
   logic [1:0]  quarter, quarterNext;
   logic [2:0]  bitcnt, bitcntNext;
   logic [30:0] acc, accNext;
   logic        ackSample, ackSampleNext;
   logic        rwLatch, rwNext;
   logic [7:0]  wrLatch, wrNext;

   logic        sclNext, rowNext, selNext, ssaNext;
   logic        writeLoadNext, shiftNext;
   logic [7:0]  sentNext;
   logic        busyNext, doneNext, ackErrNext;
   logic        advance;
   logic [3:0]  levels;

   // Quarter-tick generator: fractional accumulator, one tick per SCL/4.
   logic [30:0] step, cfWide, sum, accStep;
   logic        tickRaw, tick, stretchHold;

   always_comb begin
      step    = {9'd0, BaudRate, 2'b00};
      cfWide  = {1'b0, ClockFrequency};
      sum     = acc + step;
      tickRaw = 1'b0;
      accStep = sum;
      if (step >= cfWide) begin
         // Requested rate at or above clock/4: saturate to a tick per cycle.
         tickRaw = 1'b1;
         accStep = '0;
      end else if (sum >= cfWide) begin
         tickRaw = 1'b1;
         accStep = sum - cfWide;
      end
   end

`ifdef CLOCK_STRETCH_EN
   logic sclinQ;

   always_ff @(posedge clock) begin
      if (Reset) sclinQ <= 1'b1;
      else       sclinQ <= SCLin;
   end

   // Slave holding SCL low while we release it high freezes the timebase.
   assign stretchHold = SCL && quarter[1] && !sclinQ &&
                        (state == ADDR || state == ADDR_ACK ||
                         state == DATA || state == DATA_ACK);
`else
   assign stretchHold = 1'b0;
`endif

   assign tick = tickRaw && !stretchHold;

   // Line levels for a slot position: {SCL, ReadorWrite, Select, StartStopAck}.
   function automatic logic [3:0] slotLevels(input stateT st, input logic [1:0] q,
                                             input logic rw);
      logic [3:0] lv;
      lv = 4'b1101;
      case (st)
         START:    lv = {1'b1, 1'b1, 1'b0, ~q[1]};
         ADDR:     lv = {q[1], 1'b1, 1'b1, 1'b1};
         ADDR_ACK: lv = {q[1], 1'b0, 1'b0, 1'b1};
         DATA:     lv = {q[1], ~rw,  1'b1, 1'b1};
         DATA_ACK: lv = {q[1], rw,   1'b0, 1'b1};   // write: release; read: master NACK
         STOP:     lv = {q[1], 1'b1, 1'b0, (q == 2'd3)};
         default:  lv = 4'b1101;
      endcase
      return lv;
   endfunction

   always_comb begin
      stateNext     = state;
      quarterNext   = quarter;
      bitcntNext    = bitcnt;
      accNext       = stretchHold ? acc : accStep;
      ackSampleNext = ackSample;
      rwNext        = rwLatch;
      wrNext        = wrLatch;
      sclNext       = SCL;
      rowNext       = ReadorWrite;
      selNext       = Select;
      ssaNext       = StartStopAck;
      writeLoadNext = 1'b0;
      shiftNext     = 1'b0;
      sentNext      = SentData;
      busyNext      = Busy;
      doneNext      = 1'b0;
      ackErrNext    = AckError;
      advance       = 1'b0;
      levels        = 4'b1101;

      case (state)
         IDLE: begin
            if (Go && !Busy && BaudRate != 20'd0) begin
               stateNext   = START;
               quarterNext = 2'd0;
               bitcntNext  = 3'd7;
               accNext     = '0;
               rwNext      = RW;
               wrNext      = WrData;
               sentNext    = {SlaveAddr, RW};
               busyNext    = 1'b1;
               ackErrNext  = 1'b0;
               advance     = 1'b1;
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            if (tick) begin
               advance = 1'b1;
               if (quarter != 2'd3) begin
                  quarterNext = quarter + 2'd1;
               end else begin
                  quarterNext = 2'd0;
                  case (state)
                     START: begin
                        stateNext  = ADDR;
                        bitcntNext = 3'd7;
                     end
                     ADDR: begin
                        if (bitcnt == 3'd0) begin
                           stateNext  = ADDR_ACK;
                           bitcntNext = 3'd7;
                        end else begin
                           bitcntNext = bitcnt - 3'd1;
                        end
                     end
                     ADDR_ACK: begin
                        if (ackSample) begin
                           stateNext = STOP;
                        end else begin
                           stateNext = DATA;
                           if (!rwLatch) sentNext = wrLatch;
                        end
                     end
                     DATA: begin
                        if (bitcnt == 3'd0) begin
                           stateNext  = DATA_ACK;
                           bitcntNext = 3'd7;
                        end else begin
                           bitcntNext = bitcnt - 3'd1;
                        end
                     end
                     DATA_ACK: begin
                        stateNext = STOP;
                     end
                     STOP: begin
                        stateNext = DONE;
                        doneNext  = 1'b1;
                        busyNext  = 1'b0;
                     end
                     default: stateNext = IDLE;
                  endcase
               end

               // Tick entering q3: SCL is high and stable, so sample SDA here.
               if (quarter == 2'd2) begin
                  if (state == ADDR_ACK || (state == DATA_ACK && !rwLatch)) begin
                     ackSampleNext = SDAin;
                     if (SDAin) ackErrNext = 1'b1;
                  end
                  if (state == DATA && rwLatch) shiftNext = 1'b1;
               end
            end
         end
      endcase

      if (advance) begin
         levels  = slotLevels(stateNext, quarterNext, rwNext);
         sclNext = levels[3];
         rowNext = levels[2];
         selNext = levels[1];
         ssaNext = levels[0];
         // Transmitted bytes: load on the first bit, shift on the remaining seven.
         if (quarterNext == 2'd0 &&
             (stateNext == ADDR || (stateNext == DATA && !rwNext))) begin
            if (bitcntNext == 3'd7) writeLoadNext = 1'b1;
            else                    shiftNext     = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (Reset) begin
         state        <= IDLE;
         quarter      <= 2'd0;
         bitcnt       <= 3'd7;
         acc          <= '0;
         ackSample    <= 1'b0;
         rwLatch      <= 1'b0;
         wrLatch      <= 8'd0;
         SCL          <= 1'b1;
         ReadorWrite  <= 1'b1;
         StartStopAck <= 1'b1;
         WriteLoad    <= 1'b0;
         ShiftorHold  <= 1'b0;
         Select       <= 1'b0;
         SentData     <= 8'd0;
         Busy         <= 1'b0;
         Done         <= 1'b0;
         AckError     <= 1'b0;
      end else begin
         state        <= stateNext;
         quarter      <= quarterNext;
         bitcnt       <= bitcntNext;
         acc          <= accNext;
         ackSample    <= ackSampleNext;
         rwLatch      <= rwNext;
         wrLatch      <= wrNext;
         SCL          <= sclNext;
         ReadorWrite  <= rowNext;
         StartStopAck <= ssaNext;
         WriteLoad    <= writeLoadNext;
         ShiftorHold  <= shiftNext;
         Select       <= selNext;
         SentData     <= sentNext;
         Busy         <= busyNext;
         Done         <= doneNext;
         AckError     <= ackErrNext;
      end
   end

endmodule
